// File: rtl/clock_time_ctrl_pkg.sv
// Shared definitions for the clock time controller: FSM states, digit_blank
// bit positions, BCD field limits and a two-digit BCD increment helper.
package clock_time_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetHr  = 2'd1,
        StSetMin = 2'd2
    } state_e;

    // digit_blank bit order {hr10,hr1,min10,min1,sec10,sec1}
    localparam int unsigned BlankMin1  = 2;
    localparam int unsigned BlankMin10 = 3;
    localparam int unsigned BlankHr1   = 4;
    localparam int unsigned BlankHr10  = 5;

    localparam logic [7:0] SecMax  = 8'h59;
    localparam logic [7:0] MinMax  = 8'h59;
    localparam logic [7:0] Hr24Max = 8'h23;
    localparam logic [7:0] Hr12Max = 8'h12;

    function automatic logic [7:0] hr_max(input bit twelve_hour);
        return twelve_hour ? Hr12Max : Hr24Max;
    endfunction

    function automatic logic [7:0] hr_min(input bit twelve_hour);
        return twelve_hour ? 8'h01 : 8'h00;
    endfunction

    // Plain +1 on a packed two-digit BCD value; range wrap is handled by the caller.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Bundle of the time controller's strobes and display outputs.
// slave: the controller; master: the driver of the strobes / reader of the digits.
interface clock_time_ctrl_if;
    logic       tick_1Hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] sec_1s;
    logic [3:0] sec_10s;
    logic [3:0] min_1s;
    logic [3:0] min_10s;
    logic [3:0] hr_1s;
    logic [3:0] hr_10s;
    logic [5:0] digit_blank;
    logic       setting;
    logic       pm;

    modport slave (
        input  tick_1Hz, btn_mode, btn_inc,
        output sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s, digit_blank, setting, pm
    );

    modport master (
        output tick_1Hz, btn_mode, btn_inc,
        input  sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s, digit_blank, setting, pm
    );
endinterface

// File: rtl/clock_time_ctrl_bcd2_counter.sv
// Two-digit BCD counter: inc steps by one and wraps from max_val to min_val,
// clr loads min_val (clr wins over inc). carry_out flags an inc taken at max_val.
module clock_time_ctrl_bcd2_counter
    import clock_time_ctrl_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    input  logic [7:0] max_val,
    input  logic [7:0] min_val,
    output logic [7:0] val,
    output logic       carry_out
);

    logic [7:0] val_q;
    logic [7:0] val_d;

    // Next value: clear, wrap at max, or BCD increment.
    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = min_val;
        end else if (inc) begin
            val_d = (val_q == max_val) ? min_val : bcd2_inc(val_q);
        end
    end

    // Value register.
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= RST_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign val       = val_q;
    assign carry_out = inc && !clr && (val_q == max_val);

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping and time-set controller for the VGA clock renderer.
// Advances the six BCD digits on tick_1Hz, lets the user set hours then minutes
// with btn_mode / btn_inc, and blinks the field being edited via digit_blank.
// Optional build macro TWELVE_HOUR_EN: 01..12 hours with a PM flag and
// leading-zero suppression of the hours tens digit.
module clock_time_ctrl
    import clock_time_ctrl_pkg::*;
#(
    parameter int unsigned BLINK_TICKS      = 2,
    parameter bit          ZERO_SEC_ON_EXIT = 1'b1
) (
    input logic             clk,
    input logic             reset,
    clock_time_ctrl_if.slave bus
);

`ifdef TWELVE_HOUR_EN
    localparam bit TwelveHour = 1'b1;
`else
    localparam bit TwelveHour = 1'b0;
`endif
    localparam logic [7:0] HrMax  = hr_max(TwelveHour);
    localparam logic [7:0] HrMin  = hr_min(TwelveHour);
    localparam logic [7:0] HrRst  = TwelveHour ? Hr12Max : 8'h00;
    localparam logic [3:0] BlinkLast = 4'(BLINK_TICKS - 1);

    state_e     state_q, state_d;
    logic [3:0] blink_cnt_q, blink_cnt_d;
    logic       phase_q, phase_d;
    logic [5:0] blank_q, blank_d;
    logic       setting_q;
    logic       lead_zero;

    logic       in_run, in_set_hr, in_set_min;
    logic       sec_inc, sec_clr, min_inc, hr_inc;
    logic       sec_carry, min_carry, unused_hr_carry;
    logic [7:0] sec_val, min_val, hr_val;

    assign in_run     = (state_q == StRun);
    assign in_set_hr  = (state_q == StSetHr);
    assign in_set_min = (state_q == StSetMin);

    // Mode FSM next state: only btn_mode moves it.
    always_comb begin
        state_d = state_q;
        if (bus.btn_mode) begin
            unique case (state_q)
                StRun:    state_d = StSetHr;
                StSetHr:  state_d = StSetMin;
                StSetMin: state_d = StRun;
                default:  state_d = StRun;
            endcase
        end
    end

    // Counter controls; carries only ripple while running, edits never carry.
    assign sec_inc = in_run && bus.tick_1Hz;
    assign sec_clr = ZERO_SEC_ON_EXIT && in_set_min && bus.btn_mode;
    assign min_inc = (in_run && sec_carry) || (in_set_min && bus.btn_inc && !bus.btn_mode);
    assign hr_inc  = (in_run && min_carry) || (in_set_hr && bus.btn_inc && !bus.btn_mode);

    clock_time_ctrl_bcd2_counter #(.RST_VAL(8'h00)) u_sec (
        .clk       (clk),
        .reset     (reset),
        .inc       (sec_inc),
        .clr       (sec_clr),
        .max_val   (SecMax),
        .min_val   (8'h00),
        .val       (sec_val),
        .carry_out (sec_carry)
    );

    clock_time_ctrl_bcd2_counter #(.RST_VAL(8'h00)) u_min (
        .clk       (clk),
        .reset     (reset),
        .inc       (min_inc),
        .clr       (1'b0),
        .max_val   (MinMax),
        .min_val   (8'h00),
        .val       (min_val),
        .carry_out (min_carry)
    );

    clock_time_ctrl_bcd2_counter #(.RST_VAL(HrRst)) u_hr (
        .clk       (clk),
        .reset     (reset),
        .inc       (hr_inc),
        .clr       (1'b0),
        .max_val   (HrMax),
        .min_val   (HrMin),
        .val       (hr_val),
        .carry_out (unused_hr_carry)
    );

    // Blink counter/phase and the registered blank mask for the selected field.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        blank_d     = 6'b000000;
        // Any edit or state change restarts the blink so the field shows at once.
        if ((state_d != state_q) || bus.btn_inc) begin
            blink_cnt_d = 4'd0;
            phase_d     = 1'b0;
        end else if (bus.tick_1Hz) begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = 4'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 4'd1;
            end
        end
        unique case (state_d)
            StSetHr:  if (phase_d) blank_d[BlankHr10:BlankHr1] = 2'b11;
            StSetMin: if (phase_d) blank_d[BlankMin10:BlankMin1] = 2'b11;
            default:  blank_d = 6'b000000;
        endcase
    end

    // State, blink and output-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            blink_cnt_q <= 4'd0;
            phase_q     <= 1'b0;
            blank_q     <= 6'b000000;
            setting_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            blank_q     <= blank_d;
            setting_q   <= (state_d != StRun);
        end
    end

`ifdef TWELVE_HOUR_EN
    logic pm_q;

    // PM flips whenever the hours step from 11 to 12, running or editing.
    always_ff @(posedge clk) begin
        if (reset) begin
            pm_q <= 1'b0;
        end else if (hr_inc && (hr_val == 8'h11)) begin
            pm_q <= ~pm_q;
        end
    end

    assign bus.pm    = pm_q;
    assign lead_zero = (hr_val[7:4] == 4'd0);
`else
    assign bus.pm    = 1'b0;
    assign lead_zero = 1'b0;
`endif

    assign bus.sec_1s      = sec_val[3:0];
    assign bus.sec_10s     = sec_val[7:4];
    assign bus.min_1s      = min_val[3:0];
    assign bus.min_10s     = min_val[7:4];
    assign bus.hr_1s       = hr_val[3:0];
    assign bus.hr_10s      = hr_val[7:4];
    assign bus.digit_blank = {blank_q[BlankHr10] | lead_zero, blank_q[4:0]};
    assign bus.setting     = setting_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: directed scenarios plus random
// strobes, compared against a seconds-of-day reference model.
module tb_clock_time_ctrl;

    localparam int unsigned BLINK = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    clock_time_ctrl_if bus();

    clock_time_ctrl #(
        .BLINK_TICKS      (BLINK),
        .ZERO_SEC_ON_EXIT (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time as seconds since midnight, mode 0=run 1=hr 2=min,
    // ticks counted since the last blink restart.
    int m_t;
    int m_state;
    int m_cnt;

    function automatic void model_reset();
        m_t = 0;
        m_state = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_step(input bit tk, input bit md, input bit ic);
        int h, mi, s;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        if (md) begin
            if (m_state == 0) begin
                if (tk) m_t = (m_t + 1) % 86400;
                m_state = 1;
            end else if (m_state == 1) begin
                m_state = 2;
            end else begin
                m_t = m_t - s;
                m_state = 0;
            end
            m_cnt = 0;
        end else begin
            if (m_state == 0 && tk) m_t = (m_t + 1) % 86400;
            if (m_state == 1 && ic) m_t = ((h + 1) % 24) * 3600 + mi * 60 + s;
            if (m_state == 2 && ic) m_t = h * 3600 + ((mi + 1) % 60) * 60 + s;
            if (ic) m_cnt = 0;
            else if (tk) m_cnt++;
        end
    endfunction

    function automatic logic [31:0] exp_vec();
        int h24, hd, mi, s;
        bit pm, phase;
        logic [5:0] blank;
        h24 = m_t / 3600;
        mi  = (m_t / 60) % 60;
        s   = m_t % 60;
`ifdef TWELVE_HOUR_EN
        hd = (h24 % 12 == 0) ? 12 : h24 % 12;
        pm = (h24 >= 12);
`else
        hd = h24;
        pm = 1'b0;
`endif
        phase = ((m_cnt / BLINK) % 2) == 1;
        blank = 6'b000000;
        if (m_state == 1 && phase) blank = 6'b110000;
        if (m_state == 2 && phase) blank = 6'b001100;
`ifdef TWELVE_HOUR_EN
        if (hd < 10) blank[5] = 1'b1;
`endif
        return {4'(hd / 10), 4'(hd % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
                blank, (m_state != 0), pm};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {bus.hr_10s, bus.hr_1s, bus.min_10s, bus.min_1s, bus.sec_10s, bus.sec_1s,
                bus.digit_blank, bus.setting, bus.pm};
    endfunction

    task automatic drive(input bit tk, input bit md, input bit ic);
        bus.tick_1Hz = tk;
        bus.btn_mode = md;
        bus.btn_inc  = ic;
        @(posedge clk);
        model_step(tk, md, ic);
        #1;
        bus.tick_1Hz = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
    endtask

    task automatic do_reset();
        bus.tick_1Hz = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [31:0] e, g;
        do_reset();
        e = exp_vec(); g = dut_vec(); n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL reset_state: got %h expected %h", g, e); end
        n_checks++;
        if (bus.setting !== 1'b0) begin
            n_errors++; $display("FAIL reset_setting: got %b expected 0", bus.setting);
        end
        n_checks++;
        if (bus.digit_blank !== 6'b000000) begin
            n_errors++; $display("FAIL reset_blank: got %b expected 000000", bus.digit_blank);
        end
        n_checks++;
        if ({bus.min_10s, bus.min_1s, bus.sec_10s, bus.sec_1s} !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_minsec: got %h%h:%h%h expected 00:00", bus.min_10s, bus.min_1s,
                     bus.sec_10s, bus.sec_1s);
        end
    endtask

    task automatic test_rollover();
        logic [31:0] e, g;
        do_reset();
        drive(0, 1, 0);
        repeat (23) drive(0, 0, 1);
        drive(0, 1, 0);
        repeat (59) drive(0, 0, 1);
        drive(0, 1, 0);
        repeat (58) drive(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            e = exp_vec(); g = dut_vec(); n_checks++;
            if (g !== e) begin
                n_errors++; $display("FAIL rollover_step%0d: got %h expected %h", i, g, e);
            end
            if (i < 2) drive(1, 0, 0);
        end
        n_checks++;
        if ({bus.min_10s, bus.min_1s, bus.sec_10s, bus.sec_1s} !== 16'h0000) begin
            n_errors++;
            $display("FAIL rollover_minsec: got %h%h:%h%h expected 00:00", bus.min_10s,
                     bus.min_1s, bus.sec_10s, bus.sec_1s);
        end
    endtask

    task automatic test_set_hr();
        logic [31:0] e, g;
        do_reset();
        drive(0, 1, 0);
        for (int i = 0; i < 25; i++) begin
            drive(0, 0, 1);
            e = exp_vec(); g = dut_vec(); n_checks++;
            if (g !== e) begin
                n_errors++; $display("FAIL set_hr_inc%0d: got %h expected %h", i, g, e);
            end
        end
        n_checks++;
        if (bus.setting !== 1'b1) begin
            n_errors++; $display("FAIL set_hr_setting: got %b expected 1", bus.setting);
        end
    endtask

    task automatic test_set_min();
        logic [31:0] e, g;
        do_reset();
        repeat (37) drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        repeat (59) drive(0, 0, 1);
        n_checks++;
        if ({bus.min_10s, bus.min_1s, bus.sec_10s, bus.sec_1s} !== 16'h5937) begin
            n_errors++;
            $display("FAIL set_min_preload: got %h%h:%h%h expected 59:37", bus.min_10s,
                     bus.min_1s, bus.sec_10s, bus.sec_1s);
        end
        drive(0, 0, 1);
        e = exp_vec(); g = dut_vec(); n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL set_min_wrap: got %h expected %h", g, e); end
        drive(0, 1, 0);
        e = exp_vec(); g = dut_vec(); n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL set_min_exit: got %h expected %h", g, e); end
        n_checks++;
        if ({bus.sec_10s, bus.sec_1s, bus.setting} !== 9'h000) begin
            n_errors++;
            $display("FAIL set_min_exit_sec: got sec %h%h setting %b expected 00 0",
                     bus.sec_10s, bus.sec_1s, bus.setting);
        end
    endtask

    task automatic test_blink();
        logic [31:0] e, g;
        do_reset();
        drive(0, 1, 0);
        drive(1, 0, 0);
        n_checks++;
        if (bus.digit_blank[4] !== 1'b0) begin
            n_errors++; $display("FAIL blink_one_tick: got %b expected 0", bus.digit_blank[4]);
        end
        drive(1, 0, 0);
        n_checks++;
        if (bus.digit_blank[4] !== 1'b1) begin
            n_errors++; $display("FAIL blink_two_ticks: got %b expected 1", bus.digit_blank[4]);
        end
        drive(0, 0, 1);
        n_checks++;
        if (bus.digit_blank[4] !== 1'b0) begin
            n_errors++; $display("FAIL blink_inc_clear: got %b expected 0", bus.digit_blank[4]);
        end
        drive(0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0);
            e = exp_vec(); g = dut_vec(); n_checks++;
            if (g !== e) begin
                n_errors++; $display("FAIL blink_min_tick%0d: got %h expected %h", i, g, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] e, g;
        do_reset();
        drive(1, 1, 0);
        n_checks++;
        if ({bus.sec_1s, bus.setting} !== 5'b0001_1) begin
            n_errors++;
            $display("FAIL tick_mode_run: got sec1 %h setting %b expected 1 1", bus.sec_1s,
                     bus.setting);
        end
        repeat (3) drive(0, 0, 1);
        drive(0, 1, 1);
        e = exp_vec(); g = dut_vec(); n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL mode_inc_same: got %h expected %h", g, e); end
        drive(0, 0, 1);
        drive(1, 0, 0);
        do_reset();
        e = exp_vec(); g = dut_vec(); n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL reset_mid_set: got %h expected %h", g, e); end
        n_checks++;
        if (bus.setting !== 1'b0) begin
            n_errors++; $display("FAIL reset_mid_setting: got %b expected 0", bus.setting);
        end
    endtask

    task automatic test_random(input int cycles, input int tick_pct);
        logic [31:0] e, g;
        bit tk, md, ic;
        int bad = 0;
        do_reset();
        for (int i = 0; i < cycles; i++) begin
            tk = ($urandom_range(99) < tick_pct);
            md = ($urandom_range(99) < 3);
            ic = ($urandom_range(99) < 25);
            drive(tk, md, ic);
            e = exp_vec(); g = dut_vec(); n_checks++;
            if (g !== e) begin
                n_errors++;
                if (bad < 10) $display("FAIL random_cycle%0d: got %h expected %h", i, g, e);
                bad++;
            end
        end
    endtask

    initial begin
        bus.tick_1Hz = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        model_reset();
        test_reset();
        test_rollover();
        test_set_hr();
        test_set_min();
        test_blink();
        test_simultaneous();
        test_random(3000, 30);
        test_random(5000, 95);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
